poci_transmitter: RTL and testbench



---
 rtl/pico_poci_pkg.sv | 15 +
 rtl/p2s_shift_register.sv | 45 ++++
 rtl/poci_transmitter.sv | 108 ++++++++++
 tb/tb_poci_transmitter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pico_poci_pkg.sv
// Shared definitions for the POCI serial transmit path: default widths,
// idle line level and the transmitter state encoding.
package pico_poci_pkg;

  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_ADDR_W    = 8;
  localparam logic        POCI_IDLE_BIT = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } poci_state_t;

endpackage

// File: rtl/p2s_shift_register.sv
// Parallel-in / serial-out shift register, MSB first, with a bit counter.
// Ports:
//   clk, rstn  clock and asynchronous active-low reset
//   load       capture din into the register and clear the bit counter
//   shift      shift left by one and advance the bit counter
//   din        parallel load data
//   msb        current MSB of the register (the bit on the wire)
//   last_bit   high while the final bit of the word is being presented
module p2s_shift_register
  import pico_poci_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              msb,
  output logic              last_bit
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt;

  // Load has priority so a reload on the last bit restarts the count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (load) begin
      shift_reg <= din;
      bit_cnt   <= '0;
    end else if (shift) begin
      shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
      bit_cnt   <= bit_cnt + CNT_W'(1);
    end
  end

  assign msb      = shift_reg[DATA_W-1];
  assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/poci_transmitter.sv
// POCI transmitter: on an address strobe reads the register file at that
// address and streams it out MSB first, auto-incrementing the address
// after every byte until tx_en drops or reset.
// Ports:
//   sclk, rstn   SPI clock (posedge) and asynchronous active-low reset
//   tx_en        transmit enable; low returns to IDLE at the next edge
//   addr_load    one-cycle start strobe, start address on addr_in
//   addr_in      start register address
//   rd_data      combinational register-file read data for rd_addr
//   rd_addr      register-file read address
//   serial_out   serial data, MSB first; IDLE_BIT when not shifting
//   tx_busy      high in LOAD or SHIFT
//   byte_done    one-cycle pulse per completed byte
//   byte_count   bytes completed since the last addr_load, saturating
module poci_transmitter
  import pico_poci_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter logic        IDLE_BIT = POCI_IDLE_BIT
) (
  input  logic              sclk,
  input  logic              rstn,
  input  logic              tx_en,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              serial_out,
  output logic              tx_busy,
  output logic              byte_done,
  output logic [7:0]        byte_count
);

  poci_state_t state;
  logic        sr_load;
  logic        sr_shift;
  logic        sr_msb;
  logic        last_bit;
  logic        hold_path;

  // A disable or restart on this edge means the shifter contents are moot.
  assign hold_path = !tx_en || addr_load;
  assign sr_load   = !hold_path && ((state == LOAD) || ((state == SHIFT) && last_bit));
  assign sr_shift  = !hold_path && (state == SHIFT) && !last_bit;

  p2s_shift_register #(
    .DATA_W (DATA_W)
  ) u_p2s (
    .clk      (sclk),
    .rstn     (rstn),
    .load     (sr_load),
    .shift    (sr_shift),
    .din      (rd_data),
    .msb      (sr_msb),
    .last_bit (last_bit)
  );

  // Control FSM, address counter and byte counter.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      rd_addr    <= '0;
      tx_busy    <= 1'b0;
      byte_done  <= 1'b0;
      byte_count <= '0;
    end else begin
      byte_done <= 1'b0;
      if (!tx_en) begin
        // Disable wins over a simultaneous strobe; address and count hold.
        state   <= IDLE;
        tx_busy <= 1'b0;
      end else if (addr_load) begin
        // Start, or abort the current byte and restart at addr_in.
        state      <= LOAD;
        tx_busy    <= 1'b1;
        rd_addr    <= addr_in;
        byte_count <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= IDLE;
          end
          LOAD: begin
            state   <= SHIFT;
            rd_addr <= rd_addr + ADDR_W'(1);
          end
          SHIFT: begin
            if (last_bit) begin
              rd_addr   <= rd_addr + ADDR_W'(1);
              byte_done <= 1'b1;
              if (byte_count != 8'hFF) begin
                byte_count <= byte_count + 8'd1;
              end
            end
          end
          default: begin
            state   <= IDLE;
            tx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  assign serial_out = (state == SHIFT) ? sr_msb : IDLE_BIT;

endmodule

// File: tb/tb_poci_transmitter.sv
// Testbench for poci_transmitter. Expected values come from a stream model:
// after a strobe at edge N, edge N+1+j carries bit (7 - j%8) of
// mem[A + j/8], with rd_addr = A+1+j/8, byte_done on j%8==0 (j>0) and
// byte_count = j/8 saturating at 255.
module tb_poci_transmitter;

  logic       sclk = 1'b0;
  logic       rstn;
  logic       tx_en;
  logic       addr_load;
  logic [7:0] addr_in;
  logic [7:0] rd_data;
  logic [7:0] rd_addr;
  logic       serial_out;
  logic       tx_busy;
  logic       byte_done;
  logic [7:0] byte_count;

  logic [7:0] mem [256];
  logic       glitch_on;
  logic       sample_ok;
  logic [7:0] glitch_val;

  int n_cmp;
  int n_fail;

  // Register-file read path; garbage is injected except on capture edges.
  assign rd_data = (glitch_on && !sample_ok) ? glitch_val : mem[rd_addr];

  always #5 sclk = ~sclk;

  poci_transmitter dut (
    .sclk       (sclk),
    .rstn       (rstn),
    .tx_en      (tx_en),
    .addr_load  (addr_load),
    .addr_in    (addr_in),
    .rd_data    (rd_data),
    .rd_addr    (rd_addr),
    .serial_out (serial_out),
    .tx_busy    (tx_busy),
    .byte_done  (byte_done),
    .byte_count (byte_count)
  );

  function automatic logic exp_bit(input logic [7:0] a, input int j);
    logic [7:0] b;
    b = mem[8'(int'(a) + j / 8)];
    return b[7 - (j % 8)];
  endfunction

  function automatic logic [7:0] exp_addr(input logic [7:0] a, input int j);
    return 8'(int'(a) + 1 + j / 8);
  endfunction

  function automatic logic [7:0] sat8(input int n);
    return (n > 255) ? 8'hFF : 8'(n);
  endfunction

  task automatic step;
    @(posedge sclk);
    #1;
  endtask

  // Pulse addr_load for one edge with tx_en high.
  task automatic start(input logic [7:0] a);
    tx_en     = 1'b1;
    addr_in   = a;
    addr_load = 1'b1;
    step();
    addr_load = 1'b0;
  endtask

  task automatic test_reset;
    logic [12:0] exp;
    n_cmp++;
    if ({serial_out, tx_busy, byte_done, rd_addr, byte_count} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_state: got %b_%b_%b_%h_%h want all zero",
               serial_out, tx_busy, byte_done, rd_addr, byte_count);
    end
    rstn = 1'b1;
    mem[8'h10] = 8'hA5;
    start(8'h10);
    for (int j = 0; j < 3; j++) begin
      step();
      n_cmp++;
      if (serial_out !== exp_bit(8'h10, j)) begin
        n_fail++;
        $display("FAIL reset_prebits j=%0d: got %b want %b", j, serial_out, exp_bit(8'h10, j));
      end
    end
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({serial_out, tx_busy, byte_done, rd_addr, byte_count} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_midshift: got %b_%b_%b_%h_%h want all zero",
               serial_out, tx_busy, byte_done, rd_addr, byte_count);
    end
    #2;
    rstn = 1'b1;
    exp = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if ({serial_out, tx_busy, byte_done, rd_addr} !== {exp[2:0], 8'h00}) begin
        n_fail++;
        $display("FAIL reset_release k=%0d: got %b_%b_%b_%h want 0_0_0_00",
                 k, serial_out, tx_busy, byte_done, rd_addr);
      end
    end
    tx_en = 1'b0;
    step();
  endtask

  task automatic test_single_byte;
    logic [7:0] a;
    a = 8'h10;
    mem[8'h10] = 8'hA5;
    mem[8'h11] = 8'($urandom);
    start(a);
    n_cmp++;
    if ({serial_out, tx_busy, byte_done, rd_addr, byte_count} !== {3'b010, a, 8'h00}) begin
      n_fail++;
      $display("FAIL single_load: got %b_%b_%b_%h_%h want 0_1_0_%h_00",
               serial_out, tx_busy, byte_done, rd_addr, byte_count, a);
    end
    for (int j = 0; j < 9; j++) begin
      step();
      n_cmp++;
      if ({serial_out, tx_busy, byte_done, rd_addr, byte_count} !==
          {exp_bit(a, j), 1'b1, (j > 0 && j % 8 == 0), exp_addr(a, j), sat8(j / 8)}) begin
        n_fail++;
        $display("FAIL single_stream j=%0d: got %b_%b_%b_%h_%h want %b_1_%b_%h_%h",
                 j, serial_out, tx_busy, byte_done, rd_addr, byte_count,
                 exp_bit(a, j), (j > 0 && j % 8 == 0), exp_addr(a, j), sat8(j / 8));
      end
    end
    tx_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      n_cmp++;
      if ({serial_out, tx_busy, byte_done, rd_addr, byte_count} !== {3'b000, 8'h12, 8'h01}) begin
        n_fail++;
        $display("FAIL single_idle k=%0d: got %b_%b_%b_%h_%h want 0_0_0_12_01",
                 k, serial_out, tx_busy, byte_done, rd_addr, byte_count);
      end
    end
  endtask

  task automatic test_wrap;
    logic [7:0] a;
    a = 8'hFE;
    mem[8'hFE] = 8'h3C;
    mem[8'hFF] = 8'hC3;
    mem[8'h00] = 8'h81;
    mem[8'h01] = 8'($urandom);
    start(a);
    for (int j = 0; j < 25; j++) begin
      step();
      n_cmp++;
      if ({serial_out, tx_busy, byte_done, rd_addr, byte_count} !==
          {exp_bit(a, j), 1'b1, (j > 0 && j % 8 == 0), exp_addr(a, j), sat8(j / 8)}) begin
        n_fail++;
        $display("FAIL wrap_stream j=%0d: got %b_%b_%b_%h_%h want %b_1_%b_%h_%h",
                 j, serial_out, tx_busy, byte_done, rd_addr, byte_count,
                 exp_bit(a, j), (j > 0 && j % 8 == 0), exp_addr(a, j), sat8(j / 8));
      end
    end
    tx_en = 1'b0;
    step();
    n_cmp++;
    if ({serial_out, tx_busy, byte_done, rd_addr, byte_count} !== {3'b000, 8'h02, 8'h03}) begin
      n_fail++;
      $display("FAIL wrap_idle: got %b_%b_%b_%h_%h want 0_0_0_02_03",
               serial_out, tx_busy, byte_done, rd_addr, byte_count);
    end
  endtask

  task automatic test_restart;
    logic [7:0] a;
    logic [7:0] b;
    a = 8'h10;
    b = 8'h20;
    mem[8'h10] = 8'hA5;
    mem[8'h11] = 8'($urandom);
    mem[8'h20] = 8'($urandom);
    mem[8'h21] = 8'($urandom);
    start(a);
    for (int j = 0; j < 12; j++) begin
      step();
      n_cmp++;
      if ({serial_out, byte_done, rd_addr, byte_count} !==
          {exp_bit(a, j), (j > 0 && j % 8 == 0), exp_addr(a, j), sat8(j / 8)}) begin
        n_fail++;
        $display("FAIL restart_first j=%0d: got %b_%b_%h_%h want %b_%b_%h_%h",
                 j, serial_out, byte_done, rd_addr, byte_count,
                 exp_bit(a, j), (j > 0 && j % 8 == 0), exp_addr(a, j), sat8(j / 8));
      end
    end
    start(b);
    n_cmp++;
    if ({serial_out, tx_busy, byte_done, rd_addr, byte_count} !== {3'b010, b, 8'h00}) begin
      n_fail++;
      $display("FAIL restart_load: got %b_%b_%b_%h_%h want 0_1_0_%h_00",
               serial_out, tx_busy, byte_done, rd_addr, byte_count, b);
    end
    for (int j = 0; j < 9; j++) begin
      step();
      n_cmp++;
      if ({serial_out, tx_busy, byte_done, rd_addr, byte_count} !==
          {exp_bit(b, j), 1'b1, (j > 0 && j % 8 == 0), exp_addr(b, j), sat8(j / 8)}) begin
        n_fail++;
        $display("FAIL restart_second j=%0d: got %b_%b_%b_%h_%h want %b_1_%b_%h_%h",
                 j, serial_out, tx_busy, byte_done, rd_addr, byte_count,
                 exp_bit(b, j), (j > 0 && j % 8 == 0), exp_addr(b, j), sat8(j / 8));
      end
    end
    tx_en = 1'b0;
    step();
  endtask

  task automatic test_disable_wins;
    logic [7:0] a;
    a = 8'h30;
    mem[8'h30] = 8'($urandom);
    start(a);
    for (int j = 0; j < 5; j++) begin
      step();
      n_cmp++;
      if (serial_out !== exp_bit(a, j)) begin
        n_fail++;
        $display("FAIL disable_prebits j=%0d: got %b want %b", j, serial_out, exp_bit(a, j));
      end
    end
    tx_en     = 1'b0;
    addr_load = 1'b1;
    addr_in   = 8'h55;
    for (int k = 0; k < 3; k++) begin
      step();
      addr_load = 1'b0;
      if (k == 1) tx_en = 1'b1;
      n_cmp++;
      if ({serial_out, tx_busy, byte_done, rd_addr, byte_count} !== {3'b000, 8'h31, 8'h00}) begin
        n_fail++;
        $display("FAIL disable_idle k=%0d: got %b_%b_%b_%h_%h want 0_0_0_31_00",
                 k, serial_out, tx_busy, byte_done, rd_addr, byte_count);
      end
    end
    tx_en = 1'b0;
    step();
  endtask

  task automatic test_glitch;
    logic [7:0] a;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    a = 8'($urandom);
    start(a);
    glitch_on = 1'b1;
    for (int j = 0; j < 41; j++) begin
      sample_ok  = (j % 8 == 0);
      glitch_val = 8'($urandom);
      step();
      n_cmp++;
      if ({serial_out, tx_busy, byte_done, rd_addr, byte_count} !==
          {exp_bit(a, j), 1'b1, (j > 0 && j % 8 == 0), exp_addr(a, j), sat8(j / 8)}) begin
        n_fail++;
        $display("FAIL glitch_stream j=%0d: got %b_%b_%b_%h_%h want %b_1_%b_%h_%h",
                 j, serial_out, tx_busy, byte_done, rd_addr, byte_count,
                 exp_bit(a, j), (j > 0 && j % 8 == 0), exp_addr(a, j), sat8(j / 8));
      end
    end
    glitch_on = 1'b0;
    tx_en     = 1'b0;
    step();
  endtask

  task automatic test_saturation;
    logic [7:0] a;
    logic [7:0] last_addr;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    a = 8'($urandom);
    start(a);
    for (int j = 0; j < 8 * 258 + 1; j++) begin
      step();
      n_cmp++;
      if ({serial_out, byte_done, rd_addr, byte_count} !==
          {exp_bit(a, j), (j > 0 && j % 8 == 0), exp_addr(a, j), sat8(j / 8)}) begin
        n_fail++;
        $display("FAIL sat_stream j=%0d: got %b_%b_%h_%h want %b_%b_%h_%h",
                 j, serial_out, byte_done, rd_addr, byte_count,
                 exp_bit(a, j), (j > 0 && j % 8 == 0), exp_addr(a, j), sat8(j / 8));
      end
    end
    last_addr = exp_addr(a, 8 * 258);
    tx_en = 1'b0;
    step();
    n_cmp++;
    if ({tx_busy, rd_addr, byte_count} !== {1'b0, last_addr, 8'hFF}) begin
      n_fail++;
      $display("FAIL sat_idle: got %b_%h_%h want 0_%h_ff", tx_busy, rd_addr, byte_count, last_addr);
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    rstn       = 1'b0;
    tx_en      = 1'b0;
    addr_load  = 1'b0;
    addr_in    = 8'h00;
    glitch_on  = 1'b0;
    sample_ok  = 1'b1;
    glitch_val = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    #3;
    test_reset();
    test_single_byte();
    test_wrap();
    test_restart();
    test_disable_wins();
    test_glitch();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
